// File: rtl/pipe_alu_execute_if.sv
// Execute-stage bundle between the EX pipeline register and pipe_alu_execute.
// master = upstream pipeline driving operands; slave = the execute unit.
interface pipe_alu_execute_if;
  logic        Valid;
  logic [3:0]  AluControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        HiWrite;
  logic        LoWrite;
  logic [31:0] Result;
  logic        Zero;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Stall;

  modport master (
    output Valid, AluControl, SrcA, SrcB, HiWrite, LoWrite,
    input  Result, Zero, Hi, Lo, Busy, Stall
  );

  modport slave (
    input  Valid, AluControl, SrcA, SrcB, HiWrite, LoWrite,
    output Result, Zero, Hi, Lo, Busy, Stall
  );
endinterface

// File: rtl/pipe_alu_execute.sv
// MIPS execute stage: single-cycle ALU, HI/LO pair and an iterative
// shift-add multiplier / restoring divider that stalls the pipe while busy.
module pipe_alu_execute #(
  parameter int MD_ITERS = 32
) (
  input  logic               clk,
  input  logic               reset,
  pipe_alu_execute_if.slave  ex
);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_e;

  typedef enum logic [3:0] {
    ALU_AND  = 4'h0, ALU_OR   = 4'h1, ALU_ADD  = 4'h2, ALU_SLL  = 4'h3,
    ALU_SLTU = 4'h4, ALU_SRA  = 4'h5, ALU_SUB  = 4'h6, ALU_SLT  = 4'h7,
    ALU_DIV  = 4'h8, ALU_DIVU = 4'h9, ALU_MULT = 4'hA, ALU_MULTU = 4'hB,
    ALU_SRL  = 4'hC, ALU_XOR  = 4'hD, ALU_LUI  = 4'hE, ALU_NOP  = 4'hF
  } alu_op_e;

  alu_op_e     op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  shamt;
  logic [31:0] result;

  assign op    = alu_op_e'(ex.AluControl);
  assign src_a = ex.SrcA;
  assign src_b = ex.SrcB;
  assign shamt = src_a[4:0];

  // ---------------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assigned first so no path leaves result unassigned (no latch).
    result = '0;
    case (op)
      ALU_AND:  result = src_a & src_b;
      ALU_OR:   result = src_a | src_b;
      ALU_ADD:  result = src_a + src_b;
      ALU_SLL:  result = src_b << shamt;
      ALU_SLTU: result = {31'd0, src_a < src_b};
      ALU_SRA:  result = $signed(src_b) >>> shamt;
      ALU_SUB:  result = src_a - src_b;
      ALU_SLT:  result = {31'd0, $signed(src_a) < $signed(src_b)};
      ALU_SRL:  result = src_b >> shamt;
      ALU_XOR:  result = src_a ^ src_b;
      ALU_LUI:  result = {src_b[15:0], 16'h0000};
      default:  result = '0;
    endcase
  end

  assign ex.Result = result;
  assign ex.Zero   = (result == '0);

  // ---------------------------------------------------------------------------
  // Multiply / divide engine and HI/LO
  // ---------------------------------------------------------------------------
  state_e      state_q,    state_d;
  logic [5:0]  cnt_q,      cnt_d;
  logic [63:0] acc_q,      acc_d;       // product accumulator / remainder in [31:0]
  logic [63:0] mcand_q,    mcand_d;     // shifted multiplicand / divisor in [31:0]
  logic [31:0] mplier_q,   mplier_d;    // multiplier / dividend shifting into quotient
  logic        neg_res_q,  neg_res_d;
  logic        neg_rem_q,  neg_rem_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] hi_q,       hi_d;
  logic [31:0] lo_q,       lo_d;

  logic        md_req;
  logic        busy;
  logic        op_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        last_iter;

  assign md_req    = ex.Valid && (ex.AluControl[3:2] == 2'b10);
  assign busy      = (state_q != ST_IDLE);
  assign op_signed = (op == ALU_DIV) || (op == ALU_MULT);
  assign a_neg     = op_signed && src_a[31];
  assign b_neg     = op_signed && src_b[31];
  assign mag_a     = a_neg ? (~src_a + 32'd1) : src_a;
  assign mag_b     = b_neg ? (~src_b + 32'd1) : src_b;
  assign last_iter = (cnt_q == 6'(MD_ITERS - 1));

  assign ex.Busy  = busy;
  assign ex.Stall = (md_req || ex.HiWrite || ex.LoWrite) && busy;
  assign ex.Hi    = hi_q;
  assign ex.Lo    = lo_q;

  // One shift-add step
  logic [63:0] mul_acc_nxt;
  logic [63:0] mul_prod;

  assign mul_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
  assign mul_prod    = neg_res_q ? (~mul_acc_nxt + 64'd1) : mul_acc_nxt;

  // One restoring-division step: remainder < divisor keeps the difference in 32 bits
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [31:0] div_quo_nxt;
  logic [31:0] div_rem_nxt;
  logic [31:0] div_quo_fix;
  logic [31:0] div_rem_fix;

  assign div_shift   = {acc_q[31:0], mplier_q[31]};
  assign div_diff    = div_shift[31:0] - mcand_q[31:0];
  assign div_ge      = (div_shift >= {1'b0, mcand_q[31:0]});
  assign div_quo_nxt = {mplier_q[30:0], div_ge};
  assign div_rem_nxt = div_ge ? div_diff : div_shift[31:0];
  assign div_quo_fix = neg_res_q ? (~div_quo_nxt + 32'd1) : div_quo_nxt;
  assign div_rem_fix = neg_rem_q ? (~div_rem_nxt + 32'd1) : div_rem_nxt;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    dividend_d = dividend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (md_req) begin
          cnt_d      = '0;
          acc_d      = '0;
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          div_zero_d = (src_b == '0);
          dividend_d = src_a;
          if (ex.AluControl[1]) begin
            mcand_d  = {32'd0, mag_a};
            mplier_d = mag_b;
            state_d  = ST_MUL;
          end else begin
            mcand_d  = {32'd0, mag_b};
            mplier_d = mag_a;
            state_d  = ST_DIV;
          end
        end else begin
          if (ex.HiWrite) hi_d = src_a;
          if (ex.LoWrite) lo_d = src_a;
        end
      end

      ST_MUL: begin
        acc_d    = mul_acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        if (last_iter) begin
          hi_d    = mul_prod[63:32];
          lo_d    = mul_prod[31:0];
          state_d = ST_IDLE;
        end
      end

      ST_DIV: begin
        acc_d    = {32'd0, div_rem_nxt};
        mplier_d = div_quo_nxt;
        cnt_d    = cnt_q + 6'd1;
        if (last_iter) begin
          // Divide by zero reports the raw dividend with no sign correction
          if (div_zero_q) begin
            hi_d = dividend_q;
            lo_d = '1;
          end else begin
            hi_d = div_rem_fix;
            lo_d = div_quo_fix;
          end
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      dividend_q <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      dividend_q <= dividend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

endmodule

// File: tb/tb_pipe_alu_execute.sv
// Self-checking bench for pipe_alu_execute: directed plan steps plus random
// ALU and mult/div traffic compared against a behavioural reference model.
module tb_pipe_alu_execute;

  logic clk = 1'b0;
  logic reset;

  pipe_alu_execute_if bus ();

  pipe_alu_execute #(.MD_ITERS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .ex    (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  logic [31:0] ra, rb, eh, el;
  logic [3:0]  rop;
  logic        hw, lw;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference ALU from the operation table
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh, sa, sb;
    sh = {27'd0, a[4:0]};
    sa = a;
    sb = b;
    case (op)
      4'h0:    return a & b;
      4'h1:    return a | b;
      4'h2:    return a + b;
      4'h3:    return b << sh;
      4'h4:    return (a < b) ? 32'd1 : 32'd0;
      4'h5:    return sb >>> sh;
      4'h6:    return a - b;
      4'h7:    return (sa < sb) ? 32'd1 : 32'd0;
      4'hC:    return b >> sh;
      4'hD:    return a ^ b;
      4'hE:    return b * 32'h0001_0000;
      default: return 32'd0;
    endcase
  endfunction

  // Reference mult/div using native 64-bit and integer arithmetic
  task automatic ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
    longint          p;
    longint unsigned pu;
    int              sa, sb;
    sa = a;
    sb = b;
    hi = '0;
    lo = '0;
    case (op)
      4'hA: begin p = longint'(sa) * longint'(sb); hi = p[63:32]; lo = p[31:0]; end
      4'hB: begin pu = {32'd0, a} * {32'd0, b}; hi = pu[63:32]; lo = pu[31:0]; end
      4'h8: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin hi = 0; lo = 32'h8000_0000; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      4'h9: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endtask

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  task automatic alu_chk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
    bus.Valid      = 1'b0;
    bus.AluControl = op;
    bus.SrcA       = a;
    bus.SrcB       = b;
    #1;
    check(tag, bus.Result, exp);
    check({tag, "_zero"}, 32'(bus.Zero), 32'(exp == 0));
  endtask

  // Present a one-cycle MD request in the current cycle (cycle 0)
  task automatic start_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
    bus.Valid      = 1'b1;
    bus.AluControl = op;
    bus.SrcA       = a;
    bus.SrcB       = b;
    #1;
    check({tag, "_stall0"}, 32'(bus.Stall), 32'd0);
  endtask

  // Cycles 1..32 busy, results visible in cycle 33
  task automatic finish_md(input logic [31:0] hi, input logic [31:0] lo, input string tag);
    for (int c = 1; c <= 32; c++) begin
      sync();
      bus.Valid = 1'b0;
      check($sformatf("%s_busy_c%0d", tag, c), 32'(bus.Busy), 32'd1);
    end
    sync();
    check({tag, "_busy_end"}, 32'(bus.Busy), 32'd0);
    check({tag, "_hi"}, bus.Hi, hi);
    check({tag, "_lo"}, bus.Lo, lo);
    exp_hi = hi;
    exp_lo = lo;
  endtask

  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input string tag);
    sync();
    start_md(op, a, b, tag);
    finish_md(hi, lo, tag);
  endtask

  initial begin
    reset          = 1'b1;
    bus.Valid      = 1'b0;
    bus.AluControl = 4'h0;
    bus.SrcA       = '0;
    bus.SrcB       = '0;
    bus.HiWrite    = 1'b0;
    bus.LoWrite    = 1'b0;
    sync();
    sync();
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_stall", 32'(bus.Stall), 32'd0);
    check("rst_hi", bus.Hi, 32'd0);
    check("rst_lo", bus.Lo, 32'd0);
    reset = 1'b0;

    // ALU sweep and shifts with fixed expectations
    alu_chk(4'b0000, 32'hFFFF_FFF0, 32'h10, 32'h0000_0010, "and");
    alu_chk(4'b0010, 32'hFFFF_FFF0, 32'h10, 32'h0000_0000, "add");
    alu_chk(4'b0111, 32'hFFFF_FFF0, 32'h10, 32'h0000_0001, "slt");
    alu_chk(4'b0100, 32'hFFFF_FFF0, 32'h10, 32'h0000_0000, "sltu");
    alu_chk(4'b1110, 32'hFFFF_FFF0, 32'h10, 32'h0010_0000, "lui");
    alu_chk(4'b0011, 32'd4, 32'h8000_0001, 32'h0000_0010, "sll");
    alu_chk(4'b1100, 32'd4, 32'h8000_0001, 32'h0800_0000, "srl");
    alu_chk(4'b0101, 32'd4, 32'h8000_0001, 32'hF800_0000, "sra");
    alu_chk(4'b1010, 32'd6, 32'd7, 32'h0, "mult_comb");

    // Random ALU traffic
    for (int i = 0; i < 48; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rb  = (i % 5 == 0) ? ra : $urandom;
      alu_chk(rop, ra, rb, ref_alu(rop, ra, rb), $sformatf("alu_rnd%0d_op%0h", i, rop));
    end

    // Directed mult/div
    run_md(4'hA, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_m2x3");
    run_md(4'hB, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, "multu_m2x3");
    run_md(4'h8, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    run_md(4'h9, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, "divu_by0");
    run_md(4'h8, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");
    run_md(4'h8, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_by0_neg");

    // Held MD request while busy must not disturb the running MULT
    sync();
    start_md(4'hA, 32'd5, 32'd9, "held");
    for (int c = 1; c <= 32; c++) begin
      sync();
      bus.Valid      = 1'b1;
      bus.AluControl = 4'h9;
      bus.SrcA       = 32'd100;
      bus.SrcB       = 32'd9;
      #1;
      check($sformatf("held_busy_c%0d", c), 32'(bus.Busy), 32'd1);
      check($sformatf("held_stall_c%0d", c), 32'(bus.Stall), 32'd1);
    end
    sync();
    check("held_stall_end", 32'(bus.Stall), 32'd0);
    check("held_mult_hi", bus.Hi, 32'd0);
    check("held_mult_lo", bus.Lo, 32'd45);
    finish_md(32'd1, 32'd11, "held_divu");

    // MTLO issued at cycle 5 of a DIVU
    sync();
    start_md(4'h9, 32'd100, 32'd7, "mtlo");
    for (int c = 1; c <= 32; c++) begin
      sync();
      bus.Valid = 1'b0;
      if (c >= 5) begin
        bus.LoWrite    = 1'b1;
        bus.AluControl = 4'h0;
        bus.SrcA       = 32'h1234;
      end
      #1;
      check($sformatf("mtlo_stall_c%0d", c), 32'(bus.Stall), 32'(c >= 5));
    end
    sync();
    check("mtlo_busy_end", 32'(bus.Busy), 32'd0);
    check("mtlo_stall_end", 32'(bus.Stall), 32'd0);
    check("mtlo_divu_lo", bus.Lo, 32'd14);
    check("mtlo_divu_hi", bus.Hi, 32'd2);
    sync();
    bus.LoWrite = 1'b0;
    check("mtlo_lo", bus.Lo, 32'h1234);
    check("mtlo_hi", bus.Hi, 32'd2);

    // Reset at cycle 10 of a MULT discards it and clears HI/LO
    sync();
    start_md(4'hA, 32'd123456, 32'd789, "rstmid");
    for (int c = 1; c <= 10; c++) begin
      sync();
      bus.Valid = 1'b0;
      check($sformatf("rstmid_busy_c%0d", c), 32'(bus.Busy), 32'd1);
    end
    reset = 1'b1;
    sync();
    check("rstmid_busy", 32'(bus.Busy), 32'd0);
    check("rstmid_stall", 32'(bus.Stall), 32'd0);
    check("rstmid_hi", bus.Hi, 32'd0);
    check("rstmid_lo", bus.Lo, 32'd0);
    reset = 1'b0;
    run_md(4'hA, 32'd6, 32'd7, 32'd0, 32'd42, "mult_6x7");

    // Random mult/div
    for (int i = 0; i < 16; i++) begin
      rop = 4'($urandom_range(8, 11));
      ra  = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      ref_md(rop, ra, rb, eh, el);
      run_md(rop, ra, rb, eh, el, $sformatf("md_rnd%0d_op%0h", i, rop));
    end

    // Random MTHI/MTLO in IDLE
    for (int i = 0; i < 6; i++) begin
      hw = 1'($urandom_range(0, 1));
      lw = 1'($urandom_range(0, 1));
      ra = $urandom;
      sync();
      bus.HiWrite = hw;
      bus.LoWrite = lw;
      bus.SrcA    = ra;
      #1;
      check($sformatf("mt%0d_stall", i), 32'(bus.Stall), 32'd0);
      sync();
      bus.HiWrite = 1'b0;
      bus.LoWrite = 1'b0;
      if (hw) exp_hi = ra;
      if (lw) exp_lo = ra;
      check($sformatf("mt%0d_hi", i), bus.Hi, exp_hi);
      check($sformatf("mt%0d_lo", i), bus.Lo, exp_lo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_alu_execute.md
Name: pipe_alu_execute

Overview:
Execute-stage datapath for the pipelined MIPS CPU. It sits directly downstream of the ALU control decoder and consumes its 4-bit AluControl code. It produces the single-cycle integer result plus a Zero flag. It also owns the HI/LO register pair and an iterative multiply/divide engine, and stalls the pipeline while that engine is busy.

Parameters:
MD_ITERS, 32, number of iteration cycles for MULT/MULTU/DIV/DIVU. Fixed at 32 for a 32-bit datapath; changing it is unsupported.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
Valid  input  1  EX stage holds a live instruction
AluControl  input  4  operation code from the ALU control decoder
SrcA  input  32  operand A (rs value; for shifts, the shift amount in [4:0], already muxed upstream)
SrcB  input  32  operand B (rt value or immediate, per AluSrc2Sel upstream)
HiWrite  input  1  MTHI: write SrcA to HI
LoWrite  input  1  MTLO: write SrcA to LO
Result  output  32  combinational ALU result
Zero  output  1  Result == 0
Hi  output  32  HI register
Lo  output  32  LO register
Busy  output  1  mult/div engine running (state != IDLE)
Stall  output  1  hold EX and earlier stages this cycle

Behaviour:
- Combinational ops, valid in the same cycle, independent of Valid:
  - 0000: A&B
  - 0001: A|B
  - 0010: A+B (mod 2^32)
  - 0011: B<<A[4:0]
  - 0100: unsigned A<B ? 1 : 0
  - 0101: arithmetic B>>>A[4:0]
  - 0110: A-B (mod 2^32)
  - 0111: signed A<B ? 1 : 0
  - 1100: logical B>>A[4:0]
  - 1101: A^B
  - 1110: B<<16
  - 1000-1011 and 1111: Result = 0
- Zero = (Result == 0).
- MD request = Valid && AluControl in {1000 DIV, 1001 DIVU, 1010 MULT, 1011 MULTU}.
- Stall = (MD request || HiWrite || LoWrite) && Busy. It is combinational. Upstream holds the instruction until Stall drops.
- FSM states: IDLE, MUL, DIV.
  - IDLE: on an MD request, latch operands, clear the iteration counter, and go to MUL or DIV at the edge.
  - MUL/DIV: one iteration per cycle. After MD_ITERS iterations, write HI/LO and return to IDLE on that same edge.
  - Timing: request presented in cycle 0 gives Busy high in cycles 1..32 and new HI/LO visible from cycle 33.
- MULT/MULTU: 64-bit product, shift-add. Signed operands use magnitudes, and the product is negated if the operand signs differ. HI = product[63:32], LO = product[31:0].
- DIV/DIVU: restoring division on magnitudes. LO = quotient, HI = remainder.
  - Signed: quotient is negated if signs differ; remainder takes the dividend's sign.
  - Divide by zero (signed or unsigned): LO = 0xFFFFFFFF, HI = dividend as presented, no sign correction.
  - Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MTHI/MTLO: in IDLE, HiWrite/LoWrite write SrcA to HI/LO at the edge; both may be asserted together.
  - While Busy, writes are blocked (Stall) and are not lost.
  - An MD request and a Hi/LoWrite never coincide (one instruction per cycle).
- Reset:
  - Affects state, HI, LO, counter and latched operands.
  - Takes priority over all activity, including mid-iteration: state goes to IDLE, Hi = Lo = 0, Busy = 0, Stall = 0, and the in-flight operation is discarded.
  - Result and Zero are combinational and unaffected.
- MD requests while Busy do not restart or disturb the running operation.

Test Plan:
- ALU sweep: A=0xFFFFFFF0, B=0x00000010. Required: 0000→0x00000010, 0010→0x00000000 with Zero=1, 0111→1, 0100→0, 1110→0x00100000.
- Shifts: A=4, B=0x80000001. Required: 0011→0x00000010, 1100→0x08000000, 0101→0xF8000000.
- MULT, A=0xFFFFFFFE (-2), B=3, one-cycle request. Required: Busy high exactly cycles 1..32; Hi=0xFFFFFFFF, Lo=0xFFFFFFFA at cycle 33. MULTU with the same operands: Hi=0x00000002, Lo=0xFFFFFFFA.
- DIV, A=-7, B=2. Required: Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU, A=7, B=0. Required: Lo=0xFFFFFFFF, Hi=7.
- MTLO A=0x1234 issued at cycle 5 of a running DIVU. Required: Stall=1 until Busy falls, then Lo=0x1234 one edge after the DIVU result lands.
- reset asserted at cycle 10 of a MULT. Required: next edge has Busy=0, Hi=Lo=0; a fresh MULT 6×7 then gives Lo=42, Hi=0.
